// File: rtl/float_4e3m_accumulate_seq.sv
// float_4e3m_accumulate_seq: sequential vector reduction in front of the 4E3M adder.
// Sums each in_last-terminated vector of 8-bit 4E3M elements by looping an accumulator
// through an external combinational adder, and emits one sum per vector.
// Optional build macro: F4E3M_ACC_RESULT_PIPE_EN registers adder_result once before use
// (ACCUM -> WAIT_RES -> ACCUM/OUT, one element every two cycles after the first).
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  element handshake; in_data element, in_last ends the vector
//   operands        {acc, element} to the adder; adder_result is its sum
//   out_valid/ready sum handshake; out_data sum, out_count elements, out_trunc cut at MAX_LEN
module float_4e3m_accumulate_seq #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic [15:0]      operands,
    input  logic [7:0]       adder_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

`ifdef F4E3M_ACC_RESULT_PIPE_EN
    typedef enum logic [1:0] {S_FIRST = 2'd0, S_ACCUM = 2'd1, S_WAIT_RES = 2'd2, S_OUT = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_FIRST = 2'd0, S_ACCUM = 2'd1, S_OUT = 2'd3} state_e;
`endif

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_e           state;
    state_e           state_next;
    logic [7:0]       acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             in_hs;
    logic             out_hs;

    // Datapath controls decoded from state
    logic             load_first;
    logic             load_add;
    logic             enter_out;
    logic             trunc_d;
    logic [7:0]       acc_d;
    logic [CNT_W-1:0] count_d;

`ifdef F4E3M_ACC_RESULT_PIPE_EN
    logic [7:0]       res_q;
    logic [7:0]       data_q;
    logic             last_q;
    logic             load_wait;
`endif

    assign in_ready  = !rst && (state == S_FIRST || state == S_ACCUM);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign count_inc = CNT_W'(count + CNT_W'(1));

`ifdef F4E3M_ACC_RESULT_PIPE_EN
    // While waiting on the registered result, hold the element that produced it
    assign operands = (state == S_WAIT_RES) ? {acc, data_q} : {acc, in_data};
`else
    assign operands = {acc, in_data};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FIRST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FIRST: begin
                if (in_hs) begin
                    state_next = (in_last || MAX_LEN == 1) ? S_OUT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_hs) begin
`ifdef F4E3M_ACC_RESULT_PIPE_EN
                    state_next = S_WAIT_RES;
`else
                    state_next = (in_last || count_inc == MAX_CNT) ? S_OUT : S_ACCUM;
`endif
                end
            end
`ifdef F4E3M_ACC_RESULT_PIPE_EN
            S_WAIT_RES: begin
                state_next = (last_q || count == MAX_CNT) ? S_OUT : S_ACCUM;
            end
`endif
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_FIRST;
                end
            end
            default: state_next = S_FIRST;
        endcase
    end

    // Output / datapath-control decode
    always_comb begin
        load_first = 1'b0;
        load_add   = 1'b0;
        enter_out  = 1'b0;
        trunc_d    = 1'b0;
        acc_d      = acc;
        count_d    = count;
`ifdef F4E3M_ACC_RESULT_PIPE_EN
        load_wait  = 1'b0;
`endif
        case (state)
            S_FIRST: begin
                load_first = in_hs;
                enter_out  = in_hs && (in_last || MAX_LEN == 1);
                acc_d      = in_data;
                count_d    = CNT_W'(1);
            end
            S_ACCUM: begin
                load_add = in_hs;
`ifndef F4E3M_ACC_RESULT_PIPE_EN
                enter_out = in_hs && (in_last || count_inc == MAX_CNT);
                trunc_d   = !in_last && (count_inc == MAX_CNT);
                acc_d     = adder_result;
                count_d   = count_inc;
`endif
            end
`ifdef F4E3M_ACC_RESULT_PIPE_EN
            S_WAIT_RES: begin
                load_wait = 1'b1;
                enter_out = last_q || (count == MAX_CNT);
                trunc_d   = !last_q && (count == MAX_CNT);
                acc_d     = res_q;
            end
`endif
            default: begin
            end
        endcase
    end

    // Accumulator, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 8'h00;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_count <= '0;
            out_trunc <= 1'b0;
`ifdef F4E3M_ACC_RESULT_PIPE_EN
            res_q     <= 8'h00;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
`endif
        end else begin
            if (load_first) begin
                acc   <= in_data;
                count <= CNT_W'(1);
            end
            if (load_add) begin
`ifdef F4E3M_ACC_RESULT_PIPE_EN
                res_q  <= adder_result;
                data_q <= in_data;
                last_q <= in_last;
`else
                acc    <= adder_result;
`endif
                count  <= count_inc;
            end
`ifdef F4E3M_ACC_RESULT_PIPE_EN
            if (load_wait) begin
                acc <= res_q;
            end
`endif
            if (enter_out) begin
                out_valid <= 1'b1;
                out_data  <= acc_d;
                out_count <= count_d;
                out_trunc <= trunc_d;
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_trunc <= 1'b0;
                count     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_float_4e3m_accumulate_seq.sv
// Self-checking bench for float_4e3m_accumulate_seq (MAX_LEN overridden to 4).
// A small adder model closes the operands/adder_result loop; expected sums are
// pushed when the vector's closing element is accepted and popped on out handshake.
module tb_float_4e3m_accumulate_seq;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CNT_W   = 5;
`ifdef F4E3M_ACC_RESULT_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic [15:0]      operands;
    logic [7:0]       adder_result;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;
    logic             adder_one;

    typedef struct {
        logic [7:0] data;
        int         count;
        logic       trunc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_acc;
    int         m_cnt;

    always #5 clk = ~clk;

    // Stand-in adder: fixed answers for the directed cases, else a wrapping byte sum
    function automatic logic [7:0] adder_fn(input logic [15:0] ops, input logic one);
        if (ops == 16'h0810) return 8'h11;
        if (ops == 16'h1118) return 8'h22;
        if (one) return 8'h01;
        return 8'(ops[15:8] + ops[7:0]);
    endfunction

    assign adder_result = adder_fn(operands, adder_one);

    float_4e3m_accumulate_seq #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .operands     (operands),
        .adder_result (adder_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_trunc    (out_trunc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one element; model the reduction at the accepting edge
    task automatic send_elem(input logic [7:0] d, input logic last);
        int  waited = 0;
        bit  done   = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 40) begin
                    check_eq("accept_timeout", 32'(in_ready), 32'd1);
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    return;
                end
            end
        end
        if (m_cnt == 0) begin
            m_acc = d;
            m_cnt = 1;
        end else begin
            check_eq("operands", 32'(operands), 32'({m_acc, d}));
            m_acc = adder_fn({m_acc, d}, adder_one);
            m_cnt++;
        end
        if (last) begin
            sb.push_back('{data: m_acc, count: m_cnt, trunc: 1'b0});
            m_cnt = 0;
        end else if (m_cnt == MAX_LEN) begin
            sb.push_back('{data: m_acc, count: m_cnt, trunc: 1'b1});
            m_cnt = 0;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Output monitor: compare each consumed sum against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("out_data", 32'(out_data), 32'(e.data));
                check_eq("out_count", 32'(out_count), 32'(e.count));
                check_eq("out_trunc", 32'(out_trunc), 32'(e.trunc));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        adder_one = 1'b0;
        m_acc     = 8'h00;
        m_cnt     = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'h00);
        check_eq("rst_out_count", 32'(out_count), 32'd0);
        check_eq("rst_out_trunc", 32'(out_trunc), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_acc", 32'(operands[15:8]), 32'h00);
        check_eq("first_ready", 32'(in_ready), 32'd1);
        tick();

        // Single element, output held until out_ready
        send_elem(8'h3A, 1'b1);
        @(negedge clk);
        check_eq("single_lat", 32'(out_valid), 32'd1);
        check_eq("single_data", 32'(out_data), 32'h3A);
        check_eq("single_ready", 32'(in_ready), 32'd0);
        repeat (2) begin
            tick();
            @(negedge clk);
            check_eq("single_hold_ready", 32'(in_ready), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check_eq("single_drop", 32'(out_valid), 32'd0);
        tick();

        // Three-element vector
        send_elem(8'h08, 1'b0);
        send_elem(8'h10, 1'b0);
        @(negedge clk);
        check_eq("rdy_after_acc", 32'(in_ready), PIPE ? 32'd0 : 32'd1);
        tick();
        @(negedge clk);
        check_eq("rdy_back", 32'(in_ready), 32'd1);
        tick();
        send_elem(8'h18, 1'b1);
        @(negedge clk);
        check_eq("vec3_lat", 32'(out_valid), PIPE ? 32'd0 : 32'd1);
        tick();
        @(negedge clk);
        check_eq("vec3_lat_b", 32'(out_valid), PIPE ? 32'd1 : 32'd0);
        repeat (3) tick();

        // Back-pressure with a pending element
        out_ready = 1'b0;
        send_elem(8'h21, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h44;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_out_data", 32'(out_data), 32'h21);
            check_eq("bp_out_count", 32'(out_count), 32'd1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        send_elem(8'h44, 1'b1);
        repeat (3) tick();

        // Truncation at MAX_LEN, in_last only on the sixth element
        adder_one = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_elem(8'(8'h10 + i), i == 5);
        end
        repeat (4) tick();
        adder_one = 1'b0;

        // Mid-vector reset discards the partial vector
        send_elem(8'h30, 1'b0);
        send_elem(8'h31, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst   = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        check_eq("midrst_acc", 32'(operands[15:8]), 32'h00);
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        tick();
        send_elem(8'h55, 1'b1);
        repeat (3) tick();

        // Random vectors with mid-vector gaps
        for (int v = 0; v < 8; v++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int e = 0; e < len; e++) begin
                send_elem(8'($urandom), e == len - 1);
                if ($urandom_range(0, 2) == 0) tick();
            end
        end

        // Drain with a bounded wait
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
